// File: rtl/rs_alu_station_pkg.sv
// ---------------------------------------------------------------------------
// rs_alu_station_pkg
//   Shared sizes, opcode constants and entry/bus record types for the ALU
//   reservation station. Also holds the operand snoop helper, which is used
//   both for capture from the result buses and for issue-time bypass.
// ---------------------------------------------------------------------------
package rs_alu_station_pkg;

  localparam int RS_SIZE  = 16;
  localparam int RS_IDX_W = $clog2(RS_SIZE);
  localparam int OP_W     = 6;
  localparam int TAG_W    = 4;
  localparam int XLEN     = 32;

  localparam logic [OP_W-1:0] OP_NOP = '0;
  localparam logic            TRUE   = 1'b1;
  localparam logic            FALSE  = 1'b0;

  // One source operand: either a pending producer tag or a captured value.
  typedef struct packed {
    logic             pending;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  value;
  } operand_t;

  typedef struct packed {
    logic             busy;
    logic [OP_W-1:0]  op;
    operand_t         j;
    operand_t         k;
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  pc;
    logic [TAG_W-1:0] reorder;
  } rs_entry_t;

  // One result broadcast bus.
  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  value;
  } cdb_t;

  // Resolve a pending operand against both broadcast buses. The ALU bus is
  // checked first so it wins if both ever carried the same tag.
  function automatic operand_t snoop(operand_t opnd, cdb_t alu, cdb_t lsb);
    operand_t res;
    res = opnd;
    if (opnd.pending) begin
      if (alu.valid && alu.tag == opnd.tag) begin
        res.pending = FALSE;
        res.value   = alu.value;
      end else if (lsb.valid && lsb.tag == opnd.tag) begin
        res.pending = FALSE;
        res.value   = lsb.value;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rs_alu_station_prio_enc.sv
// ---------------------------------------------------------------------------
// rs_prio_enc
//   Lowest-index set-bit finder.
//   i_vec   : request vector
//   o_idx   : index of the lowest set bit (0 when none)
//   o_found : at least one bit of i_vec is set
// ---------------------------------------------------------------------------
module rs_prio_enc #(
  parameter int N     = 16,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     i_vec,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_found
);

  always_comb begin
    // NOTE: every output gets a default before the loop; otherwise the
    // "no bit set" path leaves them unassigned and a latch is inferred.
    o_idx   = '0;
    o_found = 1'b0;
    // Scan downwards so the lowest set index is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_idx   = IDX_W'(i);
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rs_alu_station.sv
// ---------------------------------------------------------------------------
// rs_alu_station
//   Reservation station for integer/branch/jump ops between issue and ALU.
//   Buffers issued ops, snoops the ALU and LSB result buses for pending
//   operands, and dispatches at most one ready op per cycle (lowest index
//   first) on registered out_alu_* outputs.
//
// Ports
//   clk, rst            : rising-edge clock, asynchronous active-low reset
//   rdy                 : global enable; low freezes all state and outputs
//   in_clear            : flush, kills every entry
//   in_issue_*          : op from the decoder; out_full forbids issue
//   in_alu_cdb_*        : ALU result broadcast (valid/tag/value)
//   in_lsb_cdb_*        : load/store result broadcast (valid/tag/value)
//   out_alu_*           : registered dispatch to the ALU; op = NOP when idle
// ---------------------------------------------------------------------------
module rs_alu_station
  import rs_alu_station_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             in_clear,

  input  logic             in_issue_valid,
  input  logic [OP_W-1:0]  in_issue_op,
  input  logic [XLEN-1:0]  in_issue_vj,
  input  logic [XLEN-1:0]  in_issue_vk,
  input  logic             in_issue_qj_valid,
  input  logic             in_issue_qk_valid,
  input  logic [TAG_W-1:0] in_issue_qj,
  input  logic [TAG_W-1:0] in_issue_qk,
  input  logic [XLEN-1:0]  in_issue_imm,
  input  logic [XLEN-1:0]  in_issue_pc,
  input  logic [TAG_W-1:0] in_issue_reorder,
  output logic             out_full,

  input  logic             in_alu_cdb_valid,
  input  logic [TAG_W-1:0] in_alu_cdb_tag,
  input  logic [XLEN-1:0]  in_alu_cdb_value,
  input  logic             in_lsb_cdb_valid,
  input  logic [TAG_W-1:0] in_lsb_cdb_tag,
  input  logic [XLEN-1:0]  in_lsb_cdb_value,

  output logic             out_alu_valid,
  output logic [OP_W-1:0]  out_alu_op,
  output logic [XLEN-1:0]  out_alu_rs1,
  output logic [XLEN-1:0]  out_alu_rs2,
  output logic [XLEN-1:0]  out_alu_imm,
  output logic [XLEN-1:0]  out_alu_pc,
  output logic [TAG_W-1:0] out_alu_reorder
);

  rs_entry_t r_rs     [RS_SIZE];
  rs_entry_t w_rs_nxt [RS_SIZE];

  logic [RS_SIZE-1:0]  w_busy;
  logic [RS_SIZE-1:0]  w_ready;
  logic [RS_IDX_W-1:0] w_free_idx;
  logic [RS_IDX_W-1:0] w_ready_idx;
  logic                w_free_found;
  logic                w_ready_found;
  cdb_t                w_alu_cdb;
  cdb_t                w_lsb_cdb;
  rs_entry_t           w_issue_entry;
  rs_entry_t           w_disp;

  logic             r_alu_valid;
  logic [OP_W-1:0]  r_alu_op;
  logic [XLEN-1:0]  r_alu_rs1;
  logic [XLEN-1:0]  r_alu_rs2;
  logic [XLEN-1:0]  r_alu_imm;
  logic [XLEN-1:0]  r_alu_pc;
  logic [TAG_W-1:0] r_alu_reorder;

  assign w_alu_cdb = '{valid: in_alu_cdb_valid, tag: in_alu_cdb_tag, value: in_alu_cdb_value};
  assign w_lsb_cdb = '{valid: in_lsb_cdb_valid, tag: in_lsb_cdb_tag, value: in_lsb_cdb_value};

  // Readiness is taken from registered state only, so an operand captured at
  // an edge makes its entry eligible one cycle later.
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      w_busy[i]  = r_rs[i].busy;
      w_ready[i] = r_rs[i].busy & ~r_rs[i].j.pending & ~r_rs[i].k.pending;
    end
  end

  // A dispatch at this edge does not free a slot for this edge's issue.
  assign out_full = &w_busy;

  rs_prio_enc #(.N(RS_SIZE), .IDX_W(RS_IDX_W)) u_free_enc (
    .i_vec   (~w_busy),
    .o_idx   (w_free_idx),
    .o_found (w_free_found)
  );

  rs_prio_enc #(.N(RS_SIZE), .IDX_W(RS_IDX_W)) u_ready_enc (
    .i_vec   (w_ready),
    .o_idx   (w_ready_idx),
    .o_found (w_ready_found)
  );

  assign w_disp = r_rs[w_ready_idx];

  // New entry with issue-time bypass from whichever bus is broadcasting now.
  always_comb begin
    w_issue_entry.busy    = TRUE;
    w_issue_entry.op      = in_issue_op;
    w_issue_entry.j       = snoop('{pending: in_issue_qj_valid, tag: in_issue_qj, value: in_issue_vj},
                                  w_alu_cdb, w_lsb_cdb);
    w_issue_entry.k       = snoop('{pending: in_issue_qk_valid, tag: in_issue_qk, value: in_issue_vk},
                                  w_alu_cdb, w_lsb_cdb);
    w_issue_entry.imm     = in_issue_imm;
    w_issue_entry.pc      = in_issue_pc;
    w_issue_entry.reorder = in_issue_reorder;
  end

  // Snoop, dispatch and allocation always touch disjoint entries: dispatch
  // picks a busy entry, allocation a free one. Clear overrides all of them.
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      w_rs_nxt[i] = r_rs[i];
      if (r_rs[i].busy) begin
        w_rs_nxt[i].j = snoop(r_rs[i].j, w_alu_cdb, w_lsb_cdb);
        w_rs_nxt[i].k = snoop(r_rs[i].k, w_alu_cdb, w_lsb_cdb);
      end
    end
    if (w_ready_found) begin
      w_rs_nxt[w_ready_idx].busy = FALSE;
    end
    if (in_issue_valid && w_free_found) begin
      w_rs_nxt[w_free_idx] = w_issue_entry;
    end
    if (in_clear) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        w_rs_nxt[i].busy = FALSE;
      end
    end
  end

  // NOTE: the entry array is built from flops, not a RAM macro, so it can
  // take the async reset; resetting every field keeps X out of the payload
  // instead of relying on busy alone to mask it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        r_rs[i] <= '0;
      end
    end else if (rdy) begin
      // NOTE: state is updated with non-blocking assignments so every flop
      // samples the pre-edge value regardless of process ordering.
      for (int i = 0; i < RS_SIZE; i++) begin
        r_rs[i] <= w_rs_nxt[i];
      end
    end
  end

  // Dispatch register. Operand data holds when idle; only valid/op drop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_alu_valid   <= FALSE;
      r_alu_op      <= OP_NOP;
      r_alu_rs1     <= '0;
      r_alu_rs2     <= '0;
      r_alu_imm     <= '0;
      r_alu_pc      <= '0;
      r_alu_reorder <= '0;
    end else if (rdy) begin
      if (in_clear || !w_ready_found) begin
        r_alu_valid <= FALSE;
        r_alu_op    <= OP_NOP;
      end else begin
        r_alu_valid   <= TRUE;
        r_alu_op      <= w_disp.op;
        r_alu_rs1     <= w_disp.j.value;
        r_alu_rs2     <= w_disp.k.value;
        r_alu_imm     <= w_disp.imm;
        r_alu_pc      <= w_disp.pc;
        r_alu_reorder <= w_disp.reorder;
      end
    end
  end

  assign out_alu_valid   = r_alu_valid;
  assign out_alu_op      = r_alu_op;
  assign out_alu_rs1     = r_alu_rs1;
  assign out_alu_rs2     = r_alu_rs2;
  assign out_alu_imm     = r_alu_imm;
  assign out_alu_pc      = r_alu_pc;
  assign out_alu_reorder = r_alu_reorder;

  // Protocol checks on the surrounding pipeline.
  a_cdb_tag_unique : assert property (@(posedge clk) disable iff (!rst)
    !(in_alu_cdb_valid && in_lsb_cdb_valid && in_alu_cdb_tag == in_lsb_cdb_tag));

  a_no_issue_when_full : assert property (@(posedge clk) disable iff (!rst)
    (rdy && !in_clear && in_issue_valid) |-> !out_full);

endmodule

// File: tb/tb_rs_alu_station.sv
// ---------------------------------------------------------------------------
// tb_rs_alu_station
//   Directed bench for rs_alu_station. Inputs change and outputs are sampled
//   1 ns after each rising edge.
// ---------------------------------------------------------------------------
module tb_rs_alu_station;
  import rs_alu_station_pkg::*;

  localparam logic [OP_W-1:0] OP_ADDI = 6'd10;
  localparam logic [OP_W-1:0] OP_ADD  = 6'd2;
  localparam logic [OP_W-1:0] OP_XOR  = 6'd3;
  localparam logic [OP_W-1:0] OP_SUB  = 6'd4;
  localparam logic [OP_W-1:0] OP_OR   = 6'd5;

  logic             clk = 1'b0;
  logic             rst;
  logic             rdy;
  logic             in_clear;
  logic             in_issue_valid;
  logic [OP_W-1:0]  in_issue_op;
  logic [XLEN-1:0]  in_issue_vj, in_issue_vk;
  logic             in_issue_qj_valid, in_issue_qk_valid;
  logic [TAG_W-1:0] in_issue_qj, in_issue_qk;
  logic [XLEN-1:0]  in_issue_imm, in_issue_pc;
  logic [TAG_W-1:0] in_issue_reorder;
  logic             out_full;
  logic             in_alu_cdb_valid, in_lsb_cdb_valid;
  logic [TAG_W-1:0] in_alu_cdb_tag, in_lsb_cdb_tag;
  logic [XLEN-1:0]  in_alu_cdb_value, in_lsb_cdb_value;
  logic             out_alu_valid;
  logic [OP_W-1:0]  out_alu_op;
  logic [XLEN-1:0]  out_alu_rs1, out_alu_rs2, out_alu_imm, out_alu_pc;
  logic [TAG_W-1:0] out_alu_reorder;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rs_alu_station dut (
    .clk               (clk),
    .rst               (rst),
    .rdy               (rdy),
    .in_clear          (in_clear),
    .in_issue_valid    (in_issue_valid),
    .in_issue_op       (in_issue_op),
    .in_issue_vj       (in_issue_vj),
    .in_issue_vk       (in_issue_vk),
    .in_issue_qj_valid (in_issue_qj_valid),
    .in_issue_qk_valid (in_issue_qk_valid),
    .in_issue_qj       (in_issue_qj),
    .in_issue_qk       (in_issue_qk),
    .in_issue_imm      (in_issue_imm),
    .in_issue_pc       (in_issue_pc),
    .in_issue_reorder  (in_issue_reorder),
    .out_full          (out_full),
    .in_alu_cdb_valid  (in_alu_cdb_valid),
    .in_alu_cdb_tag    (in_alu_cdb_tag),
    .in_alu_cdb_value  (in_alu_cdb_value),
    .in_lsb_cdb_valid  (in_lsb_cdb_valid),
    .in_lsb_cdb_tag    (in_lsb_cdb_tag),
    .in_lsb_cdb_value  (in_lsb_cdb_value),
    .out_alu_valid     (out_alu_valid),
    .out_alu_op        (out_alu_op),
    .out_alu_rs1       (out_alu_rs1),
    .out_alu_rs2       (out_alu_rs2),
    .out_alu_imm       (out_alu_imm),
    .out_alu_pc        (out_alu_pc),
    .out_alu_reorder   (out_alu_reorder)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_clear          = 1'b0;
    in_issue_valid    = 1'b0;
    in_issue_op       = '0;
    in_issue_vj       = '0;
    in_issue_vk       = '0;
    in_issue_qj_valid = 1'b0;
    in_issue_qk_valid = 1'b0;
    in_issue_qj       = '0;
    in_issue_qk       = '0;
    in_issue_imm      = '0;
    in_issue_pc       = '0;
    in_issue_reorder  = '0;
    in_alu_cdb_valid  = 1'b0;
    in_alu_cdb_tag    = '0;
    in_alu_cdb_value  = '0;
    in_lsb_cdb_valid  = 1'b0;
    in_lsb_cdb_tag    = '0;
    in_lsb_cdb_value  = '0;
  endtask

  task automatic issue(input logic [OP_W-1:0] op, input logic [XLEN-1:0] vj,
                       input logic qjv, input logic [TAG_W-1:0] qj,
                       input logic [XLEN-1:0] vk, input logic [XLEN-1:0] imm,
                       input logic [XLEN-1:0] pc, input logic [TAG_W-1:0] rob);
    in_issue_valid    = 1'b1;
    in_issue_op       = op;
    in_issue_vj       = vj;
    in_issue_qj_valid = qjv;
    in_issue_qj       = qj;
    in_issue_vk       = vk;
    in_issue_qk_valid = 1'b0;
    in_issue_qk       = '0;
    in_issue_imm      = imm;
    in_issue_pc       = pc;
    in_issue_reorder  = rob;
  endtask

  task automatic alu_bcast(input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] val);
    in_alu_cdb_valid = 1'b1;
    in_alu_cdb_tag   = tag;
    in_alu_cdb_value = val;
  endtask

  initial begin
    idle();
    rdy = 1'b1;
    rst = 1'b0;
    #12;
    check("rst_valid", 64'(out_alu_valid), 64'd0);
    check("rst_op",    64'(out_alu_op),    64'(OP_NOP));
    check("rst_rs1",   64'(out_alu_rs1),   64'd0);
    check("rst_full",  64'(out_full),      64'd0);
    rst = 1'b1;
    step();

    // 1: ready ADDI dispatches one edge after issue.
    issue(OP_ADDI, 32'd5, 1'b0, 4'd0, 32'd0, 32'd7, 32'h100, 4'd3);
    step();
    idle();
    check("t1_e_valid", 64'(out_alu_valid), 64'd0);
    step();
    check("t1_valid",   64'(out_alu_valid),   64'd1);
    check("t1_op",      64'(out_alu_op),      64'(OP_ADDI));
    check("t1_rs1",     64'(out_alu_rs1),     64'd5);
    check("t1_imm",     64'(out_alu_imm),     64'd7);
    check("t1_pc",      64'(out_alu_pc),      64'h100);
    check("t1_reorder", 64'(out_alu_reorder), 64'd3);
    step();
    check("t1_e2_valid", 64'(out_alu_valid), 64'd0);
    check("t1_e2_op",    64'(out_alu_op),    64'(OP_NOP));
    check("t1_e2_hold",  64'(out_alu_rs1),   64'd5);

    // 2: ADD waits on tag 2, captured from the ALU bus two cycles later.
    issue(OP_ADD, 32'd0, 1'b1, 4'd2, 32'd10, 32'd0, 32'h104, 4'd4);
    step();
    idle();
    step();
    check("t2_wait", 64'(out_alu_valid), 64'd0);
    alu_bcast(4'd2, 32'd20);
    step();
    idle();
    check("t2_snoop_edge", 64'(out_alu_valid), 64'd0);
    step();
    check("t2_valid",   64'(out_alu_valid),   64'd1);
    check("t2_op",      64'(out_alu_op),      64'(OP_ADD));
    check("t2_rs1",     64'(out_alu_rs1),     64'd20);
    check("t2_rs2",     64'(out_alu_rs2),     64'd10);
    check("t2_reorder", 64'(out_alu_reorder), 64'd4);
    step();
    check("t2_after", 64'(out_alu_valid), 64'd0);

    // 3: issue-time bypass from the LSB bus.
    issue(OP_XOR, 32'd0, 1'b1, 4'd6, 32'd1, 32'd0, 32'h108, 4'd5);
    in_lsb_cdb_valid = 1'b1;
    in_lsb_cdb_tag   = 4'd6;
    in_lsb_cdb_value = 32'hAB;
    step();
    idle();
    check("t3_e_valid", 64'(out_alu_valid), 64'd0);
    step();
    check("t3_valid",   64'(out_alu_valid),   64'd1);
    check("t3_rs1",     64'(out_alu_rs1),     64'hAB);
    check("t3_rs2",     64'(out_alu_rs2),     64'd1);
    check("t3_reorder", 64'(out_alu_reorder), 64'd5);
    step();

    // 4: fill all 16 entries waiting on tag 9, then drain in index order.
    for (int i = 0; i < RS_SIZE; i++) begin
      issue(OP_SUB, 32'd0, 1'b1, 4'd9, XLEN'(i), 32'd0, 32'h200, TAG_W'(i));
      step();
      check($sformatf("t4_full_%0d", i), 64'(out_full), 64'(i == RS_SIZE - 1));
    end
    idle();
    alu_bcast(4'd9, 32'h900);
    step();
    idle();
    check("t4_snoop_valid", 64'(out_alu_valid), 64'd0);
    check("t4_snoop_full",  64'(out_full),      64'd1);
    for (int i = 0; i < RS_SIZE; i++) begin
      step();
      check($sformatf("t4_valid_%0d", i),   64'(out_alu_valid),   64'd1);
      check($sformatf("t4_reorder_%0d", i), 64'(out_alu_reorder), 64'(i));
      check($sformatf("t4_rs2_%0d", i),     64'(out_alu_rs2),     64'(i));
      check($sformatf("t4_rs1_%0d", i),     64'(out_alu_rs1),     64'h900);
      check($sformatf("t4_full_d%0d", i),   64'(out_full),        64'd0);
    end
    step();
    check("t4_drained", 64'(out_alu_valid), 64'd0);

    // 5: flush with five busy entries and a simultaneous ready issue.
    for (int i = 0; i < 5; i++) begin
      issue(OP_OR, 32'd0, 1'b1, 4'd12, 32'd0, 32'd0, 32'h300, TAG_W'(i));
      step();
    end
    idle();
    issue(OP_ADDI, 32'd1, 1'b0, 4'd0, 32'd0, 32'd1, 32'h400, 4'd7);
    in_clear = 1'b1;
    step();
    idle();
    check("t5_full",  64'(out_full),      64'd0);
    check("t5_valid", 64'(out_alu_valid), 64'd0);
    check("t5_op",    64'(out_alu_op),    64'(OP_NOP));
    step();
    check("t5_no_issued", 64'(out_alu_valid), 64'd0);
    alu_bcast(4'd12, 32'h55);
    step();
    idle();
    step();
    check("t5_no_killed", 64'(out_alu_valid), 64'd0);

    // 6: rdy=0 freezes dispatch and snooping; then async reset mid-cycle.
    issue(OP_OR, 32'd0, 1'b1, 4'd13, 32'd2, 32'd0, 32'h500, 4'd9);
    step();
    issue(OP_OR, 32'h11, 1'b0, 4'd0, 32'd0, 32'h22, 32'h504, 4'd8);
    step();
    idle();
    rdy = 1'b0;
    alu_bcast(4'd13, 32'h77);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("t6_hold_valid_%0d", i), 64'(out_alu_valid), 64'd0);
      check($sformatf("t6_hold_op_%0d", i),    64'(out_alu_op),    64'(OP_NOP));
    end
    rdy = 1'b1;
    idle();
    step();
    check("t6_valid",   64'(out_alu_valid),   64'd1);
    check("t6_reorder", 64'(out_alu_reorder), 64'd8);
    check("t6_rs1",     64'(out_alu_rs1),     64'h11);
    check("t6_imm",     64'(out_alu_imm),     64'h22);
    step();
    check("t6_no_capture", 64'(out_alu_valid), 64'd0);
    alu_bcast(4'd13, 32'h77);
    step();
    idle();
    step();
    check("t6_late_valid",   64'(out_alu_valid),   64'd1);
    check("t6_late_rs1",     64'(out_alu_rs1),     64'h77);
    check("t6_late_reorder", 64'(out_alu_reorder), 64'd9);
    #2;
    rst = 1'b0;
    #1;
    check("t6_rst_valid",   64'(out_alu_valid),   64'd0);
    check("t6_rst_op",      64'(out_alu_op),      64'(OP_NOP));
    check("t6_rst_rs1",     64'(out_alu_rs1),     64'd0);
    check("t6_rst_reorder", 64'(out_alu_reorder), 64'd0);
    rst = 1'b1;
    step();
    step();
    check("t6_post_valid", 64'(out_alu_valid), 64'd0);
    check("t6_post_full",  64'(out_full),      64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
